// File: rtl/bht_ctrl.sv
// Access controller for a 2-bit branch history table: shares the single table
// port between zero-latency lookups and FIFO-buffered counter updates, with a clear sweep.
module bht_ctrl #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned QDEPTH     = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              lk_valid,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              lk_ready,
  output logic              lk_pred,
  output logic [1:0]        lk_state,
  input  logic              up_valid,
  input  logic [ADDR_W-1:0] up_addr,
  input  logic              up_taken,
  output logic              up_ready,
  output logic [ADDR_W-1:0] bht_addr,
  output logic [1:0]        bht_wdata,
  output logic              bht_wr,
  input  logic [1:0]        bht_rdata,
  output logic              busy
);

  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
  localparam int unsigned STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  localparam logic [ADDR_W-1:0] CLR_LAST = {ADDR_W{1'b1}};
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(QDEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(QDEPTH);
  localparam logic [STV_W-1:0]  STV_MAX  = STV_W'(STARVE_MAX);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              taken;
  } upd_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  upd_t              fifo_q [QDEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [STV_W-1:0]  starve_q, starve_d;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic lk_grant;
  upd_t head;

  // Two-bit saturating counter with the weak-taken state skipped on a taken branch
  function automatic logic [1:0] ctr_next(input logic [1:0] cur, input logic taken);
    if (taken) begin
      ctr_next = (cur == 2'b00) ? 2'b01 : 2'b11;
    end else begin
      ctr_next = (cur == 2'b11) ? 2'b10 : 2'b00;
    end
  endfunction

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);
  assign head       = fifo_q[rd_ptr_q];
  assign up_ready   = (state_q == ST_RUN) && !fifo_full;
  assign push       = up_valid && up_ready;
  assign lk_pred    = lk_ready & bht_rdata[1];
  assign lk_state   = lk_ready ? bht_rdata : 2'b00;

  // Next-state and port arbitration; updates win once lookups have starved them
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    bht_addr  = lk_addr;
    bht_wdata = 2'b00;
    bht_wr    = 1'b0;
    lk_ready  = 1'b0;
    busy      = 1'b0;
    pop       = 1'b0;
    lk_grant  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        busy      = 1'b1;
        bht_addr  = clr_ptr_q;
        bht_wr    = !rst;
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (flush) begin
          clr_ptr_d = '0;
        end else if (clr_ptr_q == CLR_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!fifo_empty && (!lk_valid || (starve_q == STV_MAX) || fifo_full)) begin
          pop       = 1'b1;
          bht_addr  = head.addr;
          bht_wr    = 1'b1;
          bht_wdata = ctr_next(bht_rdata, head.taken);
        end else if (lk_valid) begin
          lk_grant = 1'b1;
          lk_ready = 1'b1;
        end
        if (flush) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = '0;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_ptr_d = '0;
      end
    endcase
  end

  // Queue bookkeeping and starvation counter
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (lk_grant && (starve_q != STV_MAX)) begin
      starve_d = starve_q + STV_W'(1);
    end
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      starve_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (push) begin
      fifo_q[wr_ptr_q] <= '{addr: up_addr, taken: up_taken};
    end
  end

endmodule

// File: doc/bht_ctrl.md
# bht_ctrl

Access controller for the 1024-entry, 2-bit branch history table (BHT). It shares the table's single read/write port between front-end prediction lookups and back-end resolution updates. Updates are buffered in a small FIFO and applied as single-cycle read-modify-writes of the saturating counter. A clear sweep zeroes the table after reset or on flush. It sits between the fetch stage, the branch-resolve stage and one BHT instance.

## Interface
Parameters:
- ADDR_W, 10, BHT index width; table depth is 2**ADDR_W
- QDEPTH, 4, update FIFO entries (power of two)
- STARVE_MAX, 3, consecutive lookup grants allowed while updates wait

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  start a table clear sweep and discard queued updates
- lk_valid  in  1  lookup request
- lk_addr  in  ADDR_W  lookup index
- lk_ready  out  1  lookup granted this cycle
- lk_pred  out  1  predicted taken (counter bit 1); valid when lk_ready
- lk_state  out  2  raw counter value; valid when lk_ready
- up_valid  in  1  update request
- up_addr  in  ADDR_W  update index
- up_taken  in  1  resolved outcome
- up_ready  out  1  FIFO can accept an update
- bht_addr  out  ADDR_W  BHT port index
- bht_wdata  out  2  BHT write data
- bht_wr  out  1  BHT write enable
- bht_rdata  in  2  BHT combinational read data at bht_addr
- busy  out  1  clear sweep in progress

## Operation
- States: CLEAR and RUN. Reset enters CLEAR with clr_ptr=0, FIFO empty and starve_cnt=0.
- CLEAR:
  - Each cycle: bht_addr=clr_ptr, bht_wdata=00, bht_wr=1; clr_ptr increments.
  - In the cycle with clr_ptr=2**ADDR_W-1, the write occurs and the next state is RUN.
  - busy=1, lk_ready=0, up_ready=0.
- flush in RUN: the FIFO is emptied, starve_cnt=0, and the next state is CLEAR with clr_ptr=0. Any grant in the flush cycle still completes, including an update write.
- flush in CLEAR: clr_ptr restarts at 0.
- RUN arbitration: exactly one port user per cycle.
  - The update (FIFO head) wins if the FIFO is non-empty AND (lk_valid=0 OR starve_cnt==STARVE_MAX OR FIFO full).
  - Otherwise a lookup with lk_valid=1 wins.
  - With no request, bht_wr=0, bht_addr=lk_addr and lk_ready=0.
- Lookup grant: bht_addr=lk_addr, bht_wr=0, lk_ready=1, lk_state=bht_rdata, lk_pred=bht_rdata[1].
- Update grant: bht_addr=head.addr, bht_wr=1, bht_wdata=next(bht_rdata, head.taken); the FIFO pops.
- Counter next-state (taken / not-taken):
  - 00 -> 01 / 00
  - 01 -> 11 / 00
  - 10 -> 11 / 00
  - 11 -> 11 / 10
- starve_cnt:
  - Increments when a lookup is granted while the FIFO is non-empty, saturating at STARVE_MAX.
  - Clears on an update grant or when the FIFO is empty.
- Enqueue: up_valid && up_ready pushes {up_addr, up_taken}. up_ready = RUN && count<QDEPTH; there is no pass-through when full.
- A push and a pop in the same cycle leave count unchanged. Pointers wrap modulo QDEPTH.
- Queued updates are not forwarded to lookups. A lookup sees only table contents.
- Two queued updates to the same index are applied in order; each reads the result of the earlier one.
- While rst=1:
  - bht_wr=0, lk_ready=0, up_ready=0, lk_pred=0, lk_state=00, bht_wdata=00, bht_addr=0, busy=1.
  - Counters and pointers are 0.

## Timing
- Lookup: zero latency. lk_ready, lk_pred and lk_state are combinational in the request cycle. The requester holds lk_valid/lk_addr until lk_ready.
- Update: enqueued at edge N. The earliest grant is cycle N+1, with the write at the end of that cycle. A lookup at the same index sees the new value from cycle N+2.
- Update wait bound in RUN: at most STARVE_MAX lookup grants between successive update grants while the FIFO is non-empty.
- Clear: 2**ADDR_W cycles. After rst release, lk_ready can first be 1 in cycle 2**ADDR_W (cycle 0 being the first edge after release). busy falls in the same cycle.
- Reset is asynchronous mid-sweep or mid-queue. Queued updates are lost and the sweep restarts.

## Test plan
- Reset release: bht_wr=1 for exactly 1024 cycles, with addresses 0..1023 and wdata 00. busy then drops; table reads all 00; lk_ready=0 throughout the sweep.
- Counter walk at index 5:
  - Updates T,T,T,N,N,T produce states 01,11,11,10,00,01.
  - Lookups after each update show lk_pred 0,1,1,1,0,0.
- Starvation: with FIFO holding 1 update, lk_valid held high for 10 cycles with distinct addresses. Lookups are granted in cycles 0-2, the update in cycle 3, and lookups resume in cycle 4.
- FIFO full: push 4 updates while lookups stream. up_ready drops after the 4th push; the next cycle grants an update; up_ready returns to 1 the following cycle.
- Same-index ordering: enqueue T,T to index 7 starting from 00. The table reads 11 after both writes, with no lost update.
- Flush with 3 queued updates: the next cycle enters CLEAR, busy=1, and the FIFO is empty. After 1024 cycles, all entries read 00 and none of the 3 updates were applied.
